// File: rtl/adc_ctrl_apb.sv
`timescale 1ns/1ps
// ADC conversion controller behind an APB slave: single-shot and continuous
// sampling with a programmable gap, overrun/timeout flags and a level interrupt.
module adc_ctrl_apb #(
  parameter int unsigned TIMEOUT    = 16,
  parameter logic [15:0] PERIOD_RST = 16'h0100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        SOC,
  input  logic        BUSY,
  input  logic [9:0]  DATA,
  output logic        IRQ
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_RESULT = 2'd2;
  localparam logic [1:0] A_PERIOD = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_SOC, S_ARM, S_CONV, S_DONE, S_GAP} state_t;

  state_t          state;
  state_t          state_next;
  logic            access;
  logic            xfer;
  logic            wr;
  logic            rd;
  logic            wr_ctrl;
  logic            wr_stat;
  logic            wr_period;
  logic            start;
  logic            valid_clr;
  logic            tout_hit;
  logic            done;
  logic            cont;
  logic            ie;
  logic            valid;
  logic            ovr;
  logic            tout;
  logic [9:0]      result;
  logic [15:0]     period;
  logic [15:0]     gap_len;
  logic [15:0]     gap_cnt;
  logic [TW-1:0]   timer;
  logic [31:0]     rdata_mux;
  logic            unused_bits;

  // Access phase opens the wait state; side effects land on the PREADY cycle.
  assign access    = PSEL & PENABLE & ~PREADY;
  assign xfer      = PSEL & PENABLE & PREADY;
  assign wr        = xfer & PWRITE;
  assign rd        = xfer & ~PWRITE;
  assign wr_ctrl   = wr & (PADDR[3:2] == A_CTRL) & PSTRB[0];
  assign wr_stat   = wr & (PADDR[3:2] == A_STATUS) & PSTRB[0];
  assign wr_period = wr & (PADDR[3:2] == A_PERIOD);
  assign start     = wr_ctrl & PWDATA[0];
  assign valid_clr = (wr_stat & PWDATA[1]) | (rd & (PADDR[3:2] == A_RESULT));
  assign done      = (state == S_DONE);
  assign tout_hit  = (state == S_ARM) && !BUSY && (timer == TW'(TIMEOUT - 1));

  assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16], PSTRB[3:2]};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (start) state_next = S_SOC;
      S_SOC:  state_next = S_ARM;
      S_ARM: begin
        if (BUSY)          state_next = S_CONV;
        else if (tout_hit) state_next = S_IDLE;
      end
      S_CONV: if (!BUSY) state_next = S_DONE;
      S_DONE: state_next = cont ? S_GAP : S_IDLE;
      S_GAP: begin
        if (!cont)                   state_next = S_IDLE;
        else if (gap_cnt == gap_len) state_next = S_SOC;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_mux = '0;
    case (PADDR[3:2])
      A_CTRL:   rdata_mux = {29'd0, ie, cont, 1'b0};
      A_STATUS: rdata_mux = {28'd0, tout, ovr, valid, state != S_IDLE};
      A_RESULT: rdata_mux = {22'd0, result};
      default:  rdata_mux = {16'd0, period};
    endcase
  end

  // Bus outputs, conversion strobe and interrupt.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PREADY <= 1'b0;
      PRDATA <= '0;
      SOC    <= 1'b0;
      IRQ    <= 1'b0;
    end else begin
      PREADY <= access;
      PRDATA <= (access && !PWRITE) ? rdata_mux : '0;
      SOC    <= (state_next == S_SOC);
      IRQ    <= ie & (valid | tout);
    end
  end

  // Control/status registers; hardware set events win over software clears.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cont   <= 1'b0;
      ie     <= 1'b0;
      valid  <= 1'b0;
      ovr    <= 1'b0;
      tout   <= 1'b0;
      result <= '0;
      period <= PERIOD_RST;
    end else begin
      if (tout_hit)     cont <= 1'b0;
      else if (wr_ctrl) cont <= PWDATA[1];
      if (wr_ctrl) ie <= PWDATA[2];

      if (done)           valid <= 1'b1;
      else if (valid_clr) valid <= 1'b0;

      if (done && valid && !valid_clr) ovr <= 1'b1;
      else if (wr_stat && PWDATA[2])   ovr <= 1'b0;

      if (tout_hit)                  tout <= 1'b1;
      else if (wr_stat && PWDATA[3]) tout <= 1'b0;

      if (done) result <= DATA;

      if (wr_period && PSTRB[0]) period[7:0]  <= PWDATA[7:0];
      if (wr_period && PSTRB[1]) period[15:8] <= PWDATA[15:8];
    end
  end

  // ARM timeout timer and GAP counter; the gap length is frozen on GAP entry.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      timer   <= '0;
      gap_len <= '0;
      gap_cnt <= '0;
    end else begin
      if (state == S_SOC)      timer <= '0;
      else if (state == S_ARM) timer <= timer + TW'(1);

      if (done && cont) begin
        gap_len <= period;
        gap_cnt <= '0;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_adc_ctrl_apb.sv
`timescale 1ns/1ps
// Bench for adc_ctrl_apb: APB master, behavioural ADC and a queue of expected
// read values checked as each read completes.
module tb_adc_ctrl_apb;

  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_RESULT = 32'h8;
  localparam logic [31:0] A_PERIOD = 32'hC;
  localparam int TIMEOUT = 16;
  // SOC to DONE with this ADC model: 1 SOC + 2 ARM + 10 CONV + 1 DONE.
  localparam int CONV_SPAN = 14;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        SOC;
  logic        BUSY = 1'b0;
  logic [9:0]  DATA = '0;
  logic        IRQ;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int soc_cnt = 0;
  int soc_last = 0;
  int soc_prev = 0;
  int irq_rise = 0;
  logic irq_prev = 1'b0;
  logic adc_resp = 1'b1;
  int adc_cnt = -1;
  logic [31:0] exp_q[$];

  adc_ctrl_apb #(.TIMEOUT(TIMEOUT), .PERIOD_RST(16'h0100)) dut (
    .CLK(CLK), .RST(RST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
    .PREADY(PREADY), .SOC(SOC), .BUSY(BUSY), .DATA(DATA), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  // Monitor plus ADC: BUSY rises 2 cycles after SOC and stays high 10 cycles.
  always @(negedge CLK) begin
    cyc++;
    if (SOC) begin
      soc_cnt++;
      soc_prev = soc_last;
      soc_last = cyc;
    end
    if (IRQ && !irq_prev) irq_rise = cyc;
    irq_prev = IRQ;
    if (SOC && adc_resp) adc_cnt = 0;
    else if (adc_cnt >= 0) adc_cnt++;
    BUSY = (adc_cnt >= 2) && (adc_cnt < 12);
    if (adc_cnt >= 12) adc_cnt = -1;
  end

  task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    int n = 0;
    @(posedge CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d; PSTRB = s;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    while (PREADY !== 1'b1 && n < 8) begin
      @(posedge CLK); #1;
      n++;
    end
    vectors++;
    if (PREADY !== 1'b1) begin
      errors++;
      $display("FAIL apb_pready_timeout addr=%h got %b exp 1", a, PREADY);
    end
    rd = PRDATA;
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    vectors++;
    if (PREADY !== 1'b0) begin
      errors++;
      $display("FAIL apb_pready_width addr=%h got %b exp 0", a, PREADY);
    end
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    apb(1'b1, a, d, 4'hF, rd);
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] rd);
    apb(1'b0, a, 32'h0, 4'h0, rd);
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({PREADY, SOC, IRQ} !== 3'b000 || PRDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got %b/%h exp 000/0", {PREADY, SOC, IRQ}, PRDATA);
    end
    RST = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0000_0100);
    for (int i = 0; i < 4; i++) begin
      apb_rd(32'(i * 4), d);
      e = exp_q.pop_front();
      vectors++;
      if (d !== e) begin errors++; $display("FAIL reset_reg%0d got %h exp %h", i, d, e); end
    end
  endtask

  task automatic test_apb();
    logic [31:0] d, e;
    apb(1'b1, A_PERIOD, 32'h1234_5678, 4'h0, d);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL apb_write_prdata got %h exp 0", d); end
    exp_q.push_back(32'h0000_0100);
    apb_rd(A_PERIOD, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL apb_strb0 got %h exp %h", d, e); end
    apb(1'b1, A_PERIOD, 32'h1234_5678, 4'hF, d);
    exp_q.push_back(32'h0000_5678);
    apb_rd(32'h0000_00FC, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL apb_period_full got %h exp %h", d, e); end
    apb(1'b1, A_PERIOD, 32'hFFFF_AB00, 4'h2, d);
    exp_q.push_back(32'h0000_AB78);
    apb_rd(A_PERIOD, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL apb_strb_lane1 got %h exp %h", d, e); end
    apb_wr(A_CTRL, 32'hFFFF_FFF6);
    exp_q.push_back(32'h0000_0006);
    apb_rd(32'h0000_0030, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL apb_ctrl_bits got %h exp %h", d, e); end
    apb_wr(A_CTRL, 32'h0);
    apb_wr(A_STATUS, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    apb_rd(A_STATUS, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL apb_status_idle got %h exp %h", d, e); end
    apb_wr(A_PERIOD, 32'h4);
  endtask

  task automatic test_single();
    logic [31:0] d, e;
    int n0;
    DATA = 10'h2A5;
    n0 = soc_cnt;
    apb_wr(A_CTRL, 32'h1);
    exp_q.push_back(32'h1);
    apb_rd(A_STATUS, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL single_active got %h exp %h", d, e); end
    apb_wr(A_CTRL, 32'h1);
    repeat (30) @(negedge CLK);
    vectors++;
    if (soc_cnt - n0 != 1) begin errors++; $display("FAIL single_soc_count got %0d exp 1", soc_cnt - n0); end
    exp_q.push_back(32'h2); exp_q.push_back(32'h2A5); exp_q.push_back(32'h0);
    apb_rd(A_STATUS, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL single_status got %h exp %h", d, e); end
    apb_rd(A_RESULT, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL single_result got %h exp %h", d, e); end
    apb_rd(A_STATUS, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL single_status_after_read got %h exp %h", d, e); end
  endtask

  task automatic test_continuous();
    logic [31:0] d, e;
    int n0, k;
    DATA = 10'h111;
    n0 = soc_cnt;
    apb_wr(A_CTRL, 32'h3);
    k = 0;
    while (soc_cnt < n0 + 2 && k < 100) begin @(negedge CLK); k++; end
    vectors++;
    if (soc_cnt < n0 + 2) begin errors++; $display("FAIL cont_second_soc got %0d exp 2", soc_cnt - n0); end
    DATA = 10'h222;
    apb_wr(A_CTRL, 32'h0);
    vectors++;
    if (soc_last - soc_prev != CONV_SPAN + 4 + 1) begin
      errors++;
      $display("FAIL cont_spacing got %0d exp %0d", soc_last - soc_prev, CONV_SPAN + 5);
    end
    repeat (30) @(negedge CLK);
    vectors++;
    if (soc_cnt - n0 != 2) begin errors++; $display("FAIL cont_soc_count got %0d exp 2", soc_cnt - n0); end
    exp_q.push_back(32'h6); exp_q.push_back(32'h222); exp_q.push_back(32'h4);
    apb_rd(A_STATUS, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL cont_ovr got %h exp %h", d, e); end
    apb_rd(A_RESULT, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL cont_result got %h exp %h", d, e); end
    apb_rd(A_STATUS, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL cont_read_clears_valid got %h exp %h", d, e); end
    apb_wr(A_STATUS, 32'h4);
    exp_q.push_back(32'h0);
    apb_rd(A_STATUS, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL cont_ovr_clear got %h exp %h", d, e); end
  endtask

  task automatic test_timeout();
    logic [31:0] d, e;
    adc_resp = 1'b0;
    apb_wr(A_CTRL, 32'h7);
    repeat (30) @(negedge CLK);
    vectors++;
    if (IRQ !== 1'b1) begin errors++; $display("FAIL tout_irq got %b exp 1", IRQ); end
    vectors++;
    if (irq_rise - soc_last != TIMEOUT + 2) begin
      errors++;
      $display("FAIL tout_irq_delay got %0d exp %0d", irq_rise - soc_last, TIMEOUT + 2);
    end
    exp_q.push_back(32'h8); exp_q.push_back(32'h4);
    apb_rd(A_STATUS, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL tout_status got %h exp %h", d, e); end
    apb_rd(A_CTRL, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL tout_cont_cleared got %h exp %h", d, e); end
    apb_wr(A_STATUS, 32'h8);
    repeat (2) @(negedge CLK);
    vectors++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL tout_irq_clear got %b exp 0", IRQ); end
    exp_q.push_back(32'h0);
    apb_rd(A_STATUS, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL tout_status_clear got %h exp %h", d, e); end
    apb_wr(A_CTRL, 32'h0);
    adc_resp = 1'b1;
  endtask

  task automatic test_collision();
    logic [31:0] d, e;
    int n0;
    DATA = 10'h0AA;
    apb_wr(A_CTRL, 32'h1);
    repeat (25) @(negedge CLK);
    DATA = 10'h155;
    n0 = soc_cnt;
    apb_wr(A_CTRL, 32'h1);
    // Lines the RESULT read's PREADY cycle up with the DONE cycle.
    repeat (10) @(posedge CLK);
    apb_rd(A_RESULT, d);
    repeat (10) @(negedge CLK);
    vectors++;
    if (soc_cnt - n0 != 1) begin errors++; $display("FAIL coll_soc_count got %0d exp 1", soc_cnt - n0); end
    exp_q.push_back(32'h2); exp_q.push_back(32'h155);
    apb_rd(A_STATUS, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL coll_status got %h exp %h", d, e); end
    apb_rd(A_RESULT, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL coll_result got %h exp %h", d, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    int k, n1;
    apb_wr(A_PERIOD, 32'h10);
    DATA = 10'h0F0;
    apb_wr(A_CTRL, 32'h5);
    repeat (25) @(negedge CLK);
    DATA = 10'h3FF;
    apb_wr(A_CTRL, 32'h5);
    k = 0;
    while (BUSY !== 1'b1 && k < 40) begin @(negedge CLK); k++; end
    vectors++;
    if (BUSY !== 1'b1 || IRQ !== 1'b1) begin
      errors++;
      $display("FAIL rmid_precond got busy=%b irq=%b exp 1/1", BUSY, IRQ);
    end
    #2 RST = 1'b0;
    #1;
    vectors++;
    if ({PREADY, SOC, IRQ} !== 3'b000 || PRDATA !== 32'h0) begin
      errors++;
      $display("FAIL rmid_async got %b/%h exp 000/0", {PREADY, SOC, IRQ}, PRDATA);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    n1 = soc_cnt;
    repeat (30) @(negedge CLK);
    vectors++;
    if (soc_cnt != n1) begin errors++; $display("FAIL rmid_soc got %0d exp 0", soc_cnt - n1); end
    exp_q.push_back(32'h100); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    apb_rd(A_PERIOD, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL rmid_period got %h exp %h", d, e); end
    apb_rd(A_STATUS, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL rmid_status got %h exp %h", d, e); end
    apb_rd(A_RESULT, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL rmid_result got %h exp %h", d, e); end
    apb_rd(A_CTRL, d); e = exp_q.pop_front(); vectors++;
    if (d !== e) begin errors++; $display("FAIL rmid_ctrl got %h exp %h", d, e); end
  endtask

  initial begin
    test_reset();
    test_apb();
    test_single();
    test_continuous();
    test_timeout();
    test_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule

// File: doc/adc_ctrl_apb.md
ADC_CTRL_APB -- requirements
Module: adc_ctrl_apb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles in ARM waiting for BUSY to rise.
REQ-002 SHALL have parameter PERIOD_RST, default 16'h0100: reset value of the PERIOD register.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 PSEL, PENABLE, PWRITE  input  1 each  APB select, enable and direction.
REQ-006 PADDR  input  32  APB address; only PADDR[3:2] decoded.
REQ-007 PWDATA  input  32  APB write data.
REQ-008 PSTRB  input  4  APB byte strobes; a byte lane is written only when its strobe is 1.
REQ-009 PRDATA  output  32  APB read data.
REQ-010 PREADY  output  1  APB ready.
REQ-011 SOC  output  1  start-of-conversion pulse to the ADC.
REQ-012 BUSY  input  1  ADC converting flag.
REQ-013 DATA  input  10  ADC result.
REQ-014 IRQ  output  1  registered interrupt, level.

Function
REQ-015 APB: access detected when PSEL&PENABLE&~PREADY; PREADY SHALL be 1 for exactly the next cycle, then 0; one wait state per transfer.
REQ-016 Register side effects (write update, read-clear) SHALL occur only on the PREADY=1 cycle; PRDATA SHALL be 0 whenever PREADY=0 or PWRITE=1.
REQ-017 Map by PADDR[3:2]: 0 CTRL, 1 STATUS, 2 RESULT, 3 PERIOD; unused bits read 0.
REQ-018 CTRL: bit0 START (write-1 pulse, reads 0), bit1 CONT (continuous mode), bit2 IE (interrupt enable).
REQ-019 STATUS: bit0 ACTIVE (FSM not IDLE, read-only), bit1 VALID, bit2 OVR, bit3 TOUT; bits 1-3 write-1-to-clear.
REQ-020 RESULT: bits[9:0] last captured sample, read-only; a read SHALL clear VALID.
REQ-021 PERIOD: 16-bit gap in cycles between conversions in continuous mode.
REQ-022 FSM states IDLE, SOC, ARM, CONV, DONE, GAP.
REQ-023 IDLE: START written -> SOC; START written in any other state SHALL be ignored (no queuing).
REQ-024 SOC: SOC=1 for this single cycle only; timer cleared; -> ARM.
REQ-025 ARM: BUSY=1 -> CONV; else after TIMEOUT cycles in ARM -> set TOUT, clear CONT, -> IDLE.
REQ-026 CONV: BUSY=0 -> DONE; no timeout in CONV.
REQ-027 DONE: RESULT<=DATA; OVR set if VALID already 1 and not cleared this cycle; VALID<=1; -> GAP if CONT else IDLE.
REQ-028 GAP: 16-bit counter counts PERIOD cycles then -> SOC; PERIOD=0 -> SOC next cycle; CONT cleared during GAP -> IDLE next cycle.
REQ-029 CONT cleared during SOC/ARM/CONV: current conversion SHALL complete, then IDLE.
REQ-030 RESULT read in same cycle as DONE capture: new sample wins, VALID stays 1, OVR not set.
REQ-031 Write-1-clear of a STATUS bit in the same cycle as its set event: set wins.
REQ-032 IRQ SHALL be registered IE&(VALID|TOUT), one cycle after the flag change.
REQ-033 PERIOD writes take effect at next GAP entry; a GAP in progress uses the value latched on entry.

Reset
REQ-034 RST=0 SHALL immediately force FSM IDLE and PREADY, PRDATA, SOC, IRQ to 0.
REQ-035 Reset values: CTRL 0, STATUS 0, RESULT 0, PERIOD PERIOD_RST, GAP counter and timer 0.
REQ-036 Reset mid-conversion SHALL abort without capture; BUSY/DATA ignored until a new START.

Verification
REQ-037 Single shot: write CTRL=0x1; ADC model raises BUSY 2 cycles after SOC, drops after 10, DATA=0x2A5 -> one SOC pulse, RESULT=0x2A5, STATUS=0x2, ACTIVE 0 after DONE.
REQ-038 Continuous: CTRL=0x3, PERIOD=4 -> SOC pulses spaced by conversion time + 5 cycles; unread second sample sets OVR; RESULT read clears VALID only.
REQ-039 Timeout: START with BUSY held 0 -> TOUT=1 after 16 ARM cycles, CONT=0, FSM IDLE; with IE=1, IRQ=1 one cycle later; write STATUS=0x8 clears TOUT and IRQ.
REQ-040 Collision: RESULT read on DONE cycle -> VALID=1, OVR=0; START written while ACTIVE -> no extra SOC.
REQ-041 APB: every transfer PREADY high exactly one cycle; PSTRB=0x0 write to PERIOD -> PERIOD unchanged; read of unmapped bits -> 0.
REQ-042 Reset: RST low during CONV -> SOC, IRQ, PREADY 0 immediately; after release PERIOD=0x0100, STATUS=0, no capture occurs.
